// File: rtl/latency_credit_ctrl_pkg.sv
// Shared helpers for the latency credit controller: count-width function
// and the default sizing of the return FIFO.
package latency_credit_pkg;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_FIFO_DEPTH = 8;
  localparam int DEFAULT_CNT_W      = cnt_w(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/latency_credit_ctrl_tracker.sv
// In-flight tracker for a fixed-latency pipe: a LATENCY-deep shift register of
// issue bits whose tail marks the cycle the matching word leaves the pipe.
module lat_valid_tracker #(
  parameter int LATENCY = 6,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             issue,
  output logic             strobe,
  output logic [CNT_W-1:0] inflight_count
);

  if (LATENCY == 0) begin : g_comb
    // Combinational pipe: the word returns in the cycle it is issued.
    logic unused_sigs;
    assign unused_sigs    = ^{clk, RESET};
    assign strobe         = issue;
    assign inflight_count = '0;
  end else begin : g_shift
    logic [LATENCY-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign strobe         = shift_q[LATENCY-1];
    assign inflight_count = cnt_q;

    // Advance the issue bits one stage and keep a running in-flight count.
    always_comb begin
      shift_d = (shift_q << 1) | LATENCY'(issue);
      cnt_d   = cnt_q + CNT_W'(issue) - CNT_W'(shift_q[LATENCY-1]);
    end

    // Tracker state; reset flushes all pending issue bits.
    always_ff @(posedge clk) begin
      if (RESET) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/latency_credit_ctrl.sv
// Credit-based flow controller around a fixed-latency, non-stallable pipe.
// Words are only issued when a return FIFO slot is reserved for them, so the
// FIFO cannot overflow even though the pipe never stalls.
module latency_credit_ctrl
  import latency_credit_pkg::*;
#(
  parameter int LATENCY    = 6,
  parameter int WIDTH      = 14,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            RESET,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [WIDTH-1:0]                s_data,
  output logic                            pipe_issue,
  output logic [WIDTH-1:0]                pipe_data,
  input  logic [WIDTH-1:0]                pipe_ret_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [WIDTH-1:0]                m_data,
  output logic [cnt_w(FIFO_DEPTH)-1:0]    inflight_count,
  output logic [cnt_w(FIFO_DEPTH)-1:0]    fifo_count,
  output logic                            overflow_err
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [CNT_W-1:0] credits_q, credits_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic strobe_raw, strobe, pop, full, wr_en;

  // Handshake decode: ready comes only from the registered credit count.
  always_comb begin
    s_ready    = (credits_q != '0) && !RESET;
    pipe_issue = s_valid && s_ready;
    pipe_data  = s_data;
    m_valid    = (fifo_cnt_q != '0);
    m_data     = mem_q[rd_ptr_q];
    fifo_count = fifo_cnt_q;
    overflow_err = ovf_q;
  end

  lat_valid_tracker #(
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) u_tracker (
    .clk            (clk),
    .RESET          (RESET),
    .issue          (pipe_issue),
    .strobe         (strobe_raw),
    .inflight_count (inflight_count)
  );

  // Capture/pop decisions and next-state of credits, FIFO pointers and error.
  always_comb begin
    strobe     = strobe_raw && !RESET;
    pop        = m_valid && m_ready;
    full       = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    wr_en      = strobe && (!full || pop);
    credits_d  = credits_q - CNT_W'(pipe_issue) + CNT_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d      = ovf_q || (strobe && full && !pop);
  end

  // Control state: credits restored and FIFO emptied on reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      credits_q  <= CNT_W'(FIFO_DEPTH);
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; contents are only meaningful below fifo_cnt_q, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= pipe_ret_data;
  end

endmodule

// File: tb/tb_latency_credit_ctrl.sv
// Directed bench for latency_credit_ctrl: three builds (L=6/D=8, L=6/D=4,
// L=0/D=8), each with a behavioural pipe model feeding pipe_ret_data.
module tb_latency_credit_ctrl;

  localparam int W = 14;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // ---------------- DUT A: LATENCY=6, FIFO_DEPTH=8
  logic         s_valid_a = 0, s_ready_a, pipe_issue_a, m_valid_a, m_ready_a = 0, ovf_a;
  logic [W-1:0] s_data_a = 0, pipe_data_a, ret_a, m_data_a;
  logic [3:0]   infl_a, fcnt_a;
  logic [W-1:0] sr_a [6];

  // ---------------- DUT B: LATENCY=6, FIFO_DEPTH=4
  logic         s_valid_b = 0, s_ready_b, pipe_issue_b, m_valid_b, m_ready_b = 0, ovf_b;
  logic [W-1:0] s_data_b = 0, pipe_data_b, ret_b, m_data_b;
  logic [2:0]   infl_b, fcnt_b;
  logic [W-1:0] sr_b [6];

  // ---------------- DUT C: LATENCY=0, FIFO_DEPTH=8
  logic         s_valid_c = 0, s_ready_c, pipe_issue_c, m_valid_c, m_ready_c = 0, ovf_c;
  logic [W-1:0] s_data_c = 0, pipe_data_c, m_data_c;
  logic [3:0]   infl_c, fcnt_c;

  // Pipe models: pure delay lines, independent of issue.
  always @(posedge clk) begin
    sr_a[0] <= pipe_data_a;
    sr_b[0] <= pipe_data_b;
    for (int i = 1; i < 6; i++) begin
      sr_a[i] <= sr_a[i-1];
      sr_b[i] <= sr_b[i-1];
    end
  end
  assign ret_a = sr_a[5];
  assign ret_b = sr_b[5];

  latency_credit_ctrl #(.LATENCY(6), .WIDTH(W), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .RESET(RESET), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .pipe_issue(pipe_issue_a), .pipe_data(pipe_data_a), .pipe_ret_data(ret_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .inflight_count(infl_a), .fifo_count(fcnt_a), .overflow_err(ovf_a));

  latency_credit_ctrl #(.LATENCY(6), .WIDTH(W), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .RESET(RESET), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
    .pipe_issue(pipe_issue_b), .pipe_data(pipe_data_b), .pipe_ret_data(ret_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .inflight_count(infl_b), .fifo_count(fcnt_b), .overflow_err(ovf_b));

  latency_credit_ctrl #(.LATENCY(0), .WIDTH(W), .FIFO_DEPTH(8)) dut_c (
    .clk(clk), .RESET(RESET), .s_valid(s_valid_c), .s_ready(s_ready_c), .s_data(s_data_c),
    .pipe_issue(pipe_issue_c), .pipe_data(pipe_data_c), .pipe_ret_data(pipe_data_c),
    .m_valid(m_valid_c), .m_ready(m_ready_c), .m_data(m_data_c),
    .inflight_count(infl_c), .fifo_count(fcnt_c), .overflow_err(ovf_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a new cycle: just past the rising edge, reset released by default.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // One reset cycle with all stimulus idle.
  task automatic do_reset();
    next_cycle();
    RESET = 1'b1;
    s_valid_a = 0; m_ready_a = 0; s_data_a = 0;
    s_valid_b = 0; m_ready_b = 0; s_data_b = 0;
    s_valid_c = 0; m_ready_c = 0; s_data_c = 0;
    mid();
  endtask

  logic [17:0] iss_tbl, mv_tbl;
  logic [W-1:0] nxt, exp_pop;
  logic [3:0] out_tbl [12];

  initial begin
    // ---------- reset behaviour
    next_cycle();
    RESET = 1'b1;
    s_valid_a = 1;
    mid();
    chk("rst_s_ready", s_ready_a, 0);
    chk("rst_issue", pipe_issue_a, 0);
    next_cycle();
    s_valid_a = 0;
    mid();
    chk("rst_m_valid", m_valid_a, 0);
    chk("rst_infl", infl_a, 0);
    chk("rst_fcnt", fcnt_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_ready_after", s_ready_a, 1);
    chk("rst_b_ready", s_ready_b, 1);

    // ---------- single word through LATENCY=6
    next_cycle();
    s_valid_a = 1; s_data_a = 14'h0A5; m_ready_a = 1;
    mid();
    chk("t1_issue", pipe_issue_a, 1);
    chk("t1_pdata", pipe_data_a, 14'h0A5);
    next_cycle();
    s_valid_a = 0; s_data_a = 0;
    mid();
    chk("t1_infl_c1", infl_a, 1);
    for (int c = 2; c <= 6; c++) begin
      next_cycle();
      mid();
    end
    chk("t1_mvalid_c6", m_valid_a, 0);
    next_cycle();
    mid();
    chk("t1_mvalid_c7", m_valid_a, 1);
    chk("t1_mdata_c7", m_data_a, 14'h0A5);
    chk("t1_fcnt_c7", fcnt_a, 1);
    chk("t1_infl_c7", infl_a, 0);
    next_cycle();
    mid();
    chk("t1_mvalid_c8", m_valid_a, 0);
    chk("t1_outstanding_c8", infl_a + fcnt_a, 0);

    // ---------- DEPTH=4 fill with m_ready=0
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      next_cycle();
      s_valid_b = 1; s_data_b = W'(c + 1);
      mid();
      if (c <= 3) chk("t2_issue", pipe_issue_b, 1);
      if (c == 4) begin
        chk("t2_ready_c4", s_ready_b, 0);
        chk("t2_issue_c4", pipe_issue_b, 0);
        chk("t2_infl_c4", infl_b, 4);
      end
    end
    chk("t2_fcnt_c10", fcnt_b, 4);
    chk("t2_infl_c10", infl_b, 0);
    chk("t2_ovf_c10", ovf_b, 0);
    chk("t2_mdata_c10", m_data_b, 1);

    // ---------- DEPTH=4 sustained with m_ready=1
    do_reset();
    iss_tbl = 18'b11_0000_1111_0000_1111;
    mv_tbl  = 18'b111_0000_1111_0000000;
    nxt = 1;
    exp_pop = 1;
    for (int c = 0; c < 18; c++) begin
      next_cycle();
      s_valid_b = 1; m_ready_b = 1; s_data_b = nxt;
      mid();
      chk("t3_issue", pipe_issue_b, iss_tbl[c]);
      if (iss_tbl[c]) chk("t3_pdata", pipe_data_b, nxt);
      chk("t3_mvalid", m_valid_b, mv_tbl[c]);
      if (mv_tbl[c]) begin
        chk("t3_mdata", m_data_b, exp_pop);
        exp_pop++;
      end
      if (iss_tbl[c]) nxt++;
    end

    // ---------- credits=1 with simultaneous issue and pop
    do_reset();
    out_tbl = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3};
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      s_valid_b = (c <= 2) || (c == 10);
      s_data_b  = (c == 10) ? 14'h14 : W'(14'h11 + c);
      m_ready_b = (c == 10);
      mid();
      chk("t4_outstanding", infl_b + fcnt_b, out_tbl[c]);
      chk("t4_ready", s_ready_b, 1);
      if (c == 10) begin
        chk("t4_issue_c10", pipe_issue_b, 1);
        chk("t4_mdata_c10", m_data_b, 14'h11);
      end
    end
    chk("t4_fcnt_c11", fcnt_b, 2);
    chk("t4_infl_c11", infl_b, 1);
    chk("t4_mdata_c11", m_data_b, 14'h12);

    // ---------- reset mid-flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      s_valid_a = 1; s_data_a = W'(14'h21 + c); m_ready_a = 0;
      mid();
    end
    chk("t5_infl_c2", infl_a, 2);
    next_cycle();
    RESET = 1'b1; s_valid_a = 0;
    mid();
    chk("t5_ready_in_rst", s_ready_a, 0);
    next_cycle();
    mid();
    chk("t5_mvalid_c4", m_valid_a, 0);
    chk("t5_infl_c4", infl_a, 0);
    chk("t5_fcnt_c4", fcnt_a, 0);
    chk("t5_ready_c4", s_ready_a, 1);
    for (int c = 5; c <= 10; c++) begin
      next_cycle();
      mid();
      chk("t5_stale_fcnt", fcnt_a, 0);
    end
    chk("t5_mvalid_c10", m_valid_a, 0);

    // ---------- LATENCY=0 build
    do_reset();
    next_cycle();
    s_valid_c = 1; s_data_c = 14'h3FFF;
    mid();
    chk("t6_issue", pipe_issue_c, 1);
    chk("t6_infl_c0", infl_c, 0);
    next_cycle();
    s_valid_c = 0; s_data_c = 0;
    mid();
    chk("t6_mvalid_c1", m_valid_c, 1);
    chk("t6_mdata_c1", m_data_c, 14'h3FFF);
    chk("t6_fcnt_c1", fcnt_c, 1);
    chk("t6_infl_c1", infl_c, 0);
    next_cycle();
    m_ready_c = 1;
    mid();
    next_cycle();
    m_ready_c = 0;
    mid();
    chk("t6_mvalid_c3", m_valid_c, 0);
    chk("t6_fcnt_c3", fcnt_c, 0);
    chk("t6_ovf", ovf_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
